route_unit_xy: RTL

Parametrised per-input route-computation unit for mesh routers. Each input channel computes dimension-ordered (X then Y) output ports for head flits, against the router's own address. It holds each route for the whole wormhole packet until the tail flit is forwarded. One instance sits in every router, between the input buffers and the switch allocator. Unlike the single-channel predecessor, it covers both Y directions and supports any mesh size.

---
 rtl/route_unit_xy_pkg.sv | 28 ++
 rtl/route_unit_xy_rc_channel.sv | 111 +++++++++++
 rtl/route_unit_xy.sv | 55 +++++
 3 files changed

// File: rtl/route_unit_xy_pkg.sv
// Shared port codes, channel FSM state encodings and the XY route decision
// helper for route_unit_xy.
package route_unit_xy_pkg;

  localparam logic [2:0] EMPTY          = 3'd0;
  localparam logic [2:0] OUT_LOCAL_PORT = 3'd1;
  localparam logic [2:0] OUT_X1_PORT    = 3'd2;
  localparam logic [2:0] OUT_X2_PORT    = 3'd3;
  localparam logic [2:0] OUT_Y1_PORT    = 3'd4;
  localparam logic [2:0] OUT_Y2_PORT    = 3'd5;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DROP = 2'd2;

  // X is resolved before Y; equal coordinates mean the packet has arrived.
  function automatic logic [2:0] route_code(input logic x_gt, input logic x_lt,
                                            input logic y_gt, input logic y_lt);
    logic [2:0] code;
    if (x_gt)      code = OUT_X2_PORT;
    else if (x_lt) code = OUT_X1_PORT;
    else if (y_gt) code = OUT_Y1_PORT;
    else if (y_lt) code = OUT_Y2_PORT;
    else           code = OUT_LOCAL_PORT;
    return code;
  endfunction

endpackage

// File: rtl/route_unit_xy_rc_channel.sv
// One input channel: route computation plus the IDLE/BUSY/DROP wormhole lock.
// Destination bound checking is compiled in with RC_BOUND_CHECK_EN.
module rc_channel
  import route_unit_xy_pkg::*;
#(
  parameter int X_W    = 2,
  parameter int Y_W    = 1,
  parameter int PORT_W = 3,
  parameter int MESH_X = 4,
  parameter int MESH_Y = 2,
  parameter int A_W    = X_W + Y_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [A_W-1:0]    router_add,
  input  logic              valid,
  input  logic              head,
  input  logic              tail,
  input  logic [A_W-1:0]    dst,
  input  logic              fire,
  output logic [PORT_W-1:0] port,
  output logic              route_vld,
  output logic              drop,
  output logic              err
);

  logic [1:0]        state_r;
  logic [PORT_W-1:0] port_r;
  logic              vld_r;
  logic [PORT_W-1:0] route_s;
  logic              bad_s;

  always_comb begin
    route_s = PORT_W'(route_code(dst[X_W-1:0] > router_add[X_W-1:0],
                                 dst[X_W-1:0] < router_add[X_W-1:0],
                                 dst[A_W-1:X_W] > router_add[A_W-1:X_W],
                                 dst[A_W-1:X_W] < router_add[A_W-1:X_W]));
  end

`ifdef RC_BOUND_CHECK_EN
  logic drop_r;
  logic err_r;

  assign bad_s = (32'(dst[X_W-1:0]) >= MESH_X) || (32'(dst[A_W-1:X_W]) >= MESH_Y);
  assign drop  = drop_r;
  assign err   = err_r;
`else
  assign bad_s = 1'b0;
  assign drop  = 1'b0;
  assign err   = 1'b0;
`endif

  // err_r only updates under en, so a pending pulse survives a freeze.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      port_r  <= PORT_W'(EMPTY);
      vld_r   <= 1'b0;
`ifdef RC_BOUND_CHECK_EN
      drop_r  <= 1'b0;
      err_r   <= 1'b0;
`endif
    end else if (en) begin
`ifdef RC_BOUND_CHECK_EN
      err_r <= 1'b0;
`endif
      case (state_r)
        IDLE: begin
          if (valid && head) begin
            if (bad_s) begin
              state_r <= DROP;
`ifdef RC_BOUND_CHECK_EN
              drop_r  <= 1'b1;
              err_r   <= 1'b1;
`endif
            end else begin
              state_r <= BUSY;
              port_r  <= route_s;
              vld_r   <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (fire && tail) begin
            state_r <= IDLE;
            port_r  <= PORT_W'(EMPTY);
            vld_r   <= 1'b0;
          end
        end
        DROP: begin
          if (valid && tail) begin
            state_r <= IDLE;
`ifdef RC_BOUND_CHECK_EN
            drop_r  <= 1'b0;
`endif
          end
        end
        default: begin
          state_r <= IDLE;
          port_r  <= PORT_W'(EMPTY);
          vld_r   <= 1'b0;
        end
      endcase
    end
  end

  assign port      = port_r;
  assign route_vld = vld_r;

endmodule

// File: rtl/route_unit_xy.sv
// Per-input XY route computation for a mesh router: NUM_IN independent channels.
// Optional destination bound check enabled by defining RC_BOUND_CHECK_EN.
module route_unit_xy
  import route_unit_xy_pkg::*;
#(
  parameter int X_W    = 2,
  parameter int Y_W    = 1,
  parameter int NUM_IN = 5,
  parameter int PORT_W = 3,
  parameter int MESH_X = 4,
  parameter int MESH_Y = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [X_W+Y_W-1:0]         router_add,
  input  logic [NUM_IN-1:0]          in_valid,
  input  logic [NUM_IN-1:0]          in_head,
  input  logic [NUM_IN-1:0]          in_tail,
  input  logic [NUM_IN*(X_W+Y_W)-1:0] in_dst,
  input  logic [NUM_IN-1:0]          flit_fire,
  output logic [NUM_IN*PORT_W-1:0]   port,
  output logic [NUM_IN-1:0]          route_vld,
  output logic [NUM_IN-1:0]          in_drop,
  output logic [NUM_IN-1:0]          route_err
);

  localparam int A_W = X_W + Y_W;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_ch
    rc_channel #(
      .X_W   (X_W),
      .Y_W   (Y_W),
      .PORT_W(PORT_W),
      .MESH_X(MESH_X),
      .MESH_Y(MESH_Y),
      .A_W   (A_W)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .router_add(router_add),
      .valid     (in_valid[i]),
      .head      (in_head[i]),
      .tail      (in_tail[i]),
      .dst       (in_dst[i*A_W +: A_W]),
      .fire      (flit_fire[i]),
      .port      (port[i*PORT_W +: PORT_W]),
      .route_vld (route_vld[i]),
      .drop      (in_drop[i]),
      .err       (route_err[i])
    );
  end

endmodule
